// File: rtl/fabric_bitstream_checker.sv
`default_nettype none
// ============================================================================
// Module   : fabric_bitstream_checker
// Brief    : Frames the SPI bitstream ahead of fabric_config. It waits for a
//            sync word, reads a length header and forwards that many payload
//            words. It then checks the trailer word and reports done or a
//            sticky error code.
// Option   : BITSTREAM_CRC_EN - when defined, a CRC-32 is kept over the
//            payload and compared against the trailer. When undefined, the
//            trailer word is consumed but ignored.
// Revision : 1.0 - initial release
// ============================================================================
module fabric_bitstream_checker #(
  parameter logic [31:0] SYNC_WORD      = 32'hFAB0_FAB1,
  parameter logic [31:0] MAX_LEN_WORDS  = 32'h0000_1000,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] data_i,
  input  logic        valid_i,
  input  logic        abort_i,
  output logic [31:0] data_o,
  output logic        valid_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o,
  output logic [1:0]  err_code_o
);

  localparam logic [1:0]  c_err_len     = 2'b01;
  localparam logic [1:0]  c_err_crc     = 2'b10;
  localparam logic [1:0]  c_err_timeout = 2'b11;
  localparam bit          c_timeout_en  = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] c_timeout_max = 32'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LEN     = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_TRAILER = 2'd3
  } state_t;

  state_t      r_state;
  logic [31:0] r_remaining;
  logic [31:0] r_idle_cnt;
  logic        w_timeout;
  logic        w_trailer_ok;

  // The current silent cycle is the TIMEOUT_CYCLES-th in a row inside a frame
  assign w_timeout = c_timeout_en && (r_idle_cnt == c_timeout_max);

`ifdef BITSTREAM_CRC_EN
  logic [31:0] r_crc;
  logic [31:0] w_crc_next;

  // Reflected CRC-32 over one word, bit0 first: 32 unrolled shift steps
  function automatic logic [31:0] crc32_word(input logic [31:0] crc, input logic [31:0] word);
    logic [31:0] c;
    c = crc ^ word;
    for (int i = 0; i < 32; i++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return c;
  endfunction

  assign w_crc_next   = crc32_word(r_crc, data_i);
  // Trailer carries the finalised CRC (register XOR all-ones)
  assign w_trailer_ok = (data_i == ~r_crc);

  // Running CRC: seeded when a frame starts, advanced on each payload word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_crc <= 32'hFFFF_FFFF;
    end else if (r_state == ST_IDLE) begin
      if (valid_i && (data_i == SYNC_WORD)) begin
        r_crc <= 32'hFFFF_FFFF;
      end
    end else if (r_state == ST_PAYLOAD && valid_i && !abort_i) begin
      r_crc <= w_crc_next;
    end
  end
`else
  assign w_trailer_ok = 1'b1;
`endif

  // Framing FSM with registered outputs; abort beats any word in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_remaining <= 32'd0;
      r_idle_cnt  <= 32'd0;
      data_o      <= 32'd0;
      valid_o     <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      error_o     <= 1'b0;
      err_code_o  <= 2'b00;
    end else begin
      valid_o <= 1'b0;
      done_o  <= 1'b0;
      if (r_state == ST_IDLE) begin
        if (valid_i && (data_i == SYNC_WORD)) begin
          r_state    <= ST_LEN;
          r_idle_cnt <= 32'd0;
          busy_o     <= 1'b1;
          error_o    <= 1'b0;
          err_code_o <= 2'b00;
        end
      end else if (abort_i) begin
        r_state    <= ST_IDLE;
        r_idle_cnt <= 32'd0;
        busy_o     <= 1'b0;
      end else if (valid_i) begin
        r_idle_cnt <= 32'd0;
        case (r_state)
          ST_LEN: begin
            if ((data_i == 32'd0) || (data_i > MAX_LEN_WORDS)) begin
              r_state    <= ST_IDLE;
              busy_o     <= 1'b0;
              error_o    <= 1'b1;
              err_code_o <= c_err_len;
            end else begin
              r_remaining <= data_i;
              r_state     <= ST_PAYLOAD;
            end
          end
          ST_PAYLOAD: begin
            data_o      <= data_i;
            valid_o     <= 1'b1;
            r_remaining <= r_remaining - 32'd1;
            if (r_remaining == 32'd1) begin
              r_state <= ST_TRAILER;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            busy_o  <= 1'b0;
            if (w_trailer_ok) begin
              done_o <= 1'b1;
            end else begin
              error_o    <= 1'b1;
              err_code_o <= c_err_crc;
            end
          end
        endcase
      end else if (w_timeout) begin
        r_state    <= ST_IDLE;
        r_idle_cnt <= 32'd0;
        busy_o     <= 1'b0;
        error_o    <= 1'b1;
        err_code_o <= c_err_timeout;
      end else begin
        r_idle_cnt <= r_idle_cnt + 32'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fabric_bitstream_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_fabric_bitstream_checker
// Brief    : Self-checking bench for fabric_bitstream_checker. A frame-level
//            reference model predicts every output on every cycle. Directed
//            frames and randomized frames drive the design. The bench honours
//            BITSTREAM_CRC_EN in the same way as the design.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fabric_bitstream_checker;

  localparam logic [31:0] SYNC = 32'hFAB0_FAB1;
  localparam int          MAXL = 8;
  localparam int          TMO  = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] data_i = '0;
  logic        valid_i = 1'b0;
  logic        abort_i = 1'b0;
  logic [31:0] data_o;
  logic        valid_o, busy_o, done_o, error_o;
  logic [1:0]  err_code_o;

  fabric_bitstream_checker #(
    .SYNC_WORD(SYNC), .MAX_LEN_WORDS(32'(MAXL)), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .data_i(data_i), .valid_i(valid_i), .abort_i(abort_i),
    .data_o(data_o), .valid_o(valid_o), .busy_o(busy_o), .done_o(done_o),
    .error_o(error_o), .err_code_o(err_code_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int mon_valid = 0;
  int mon_done = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Standard CRC-32 over the payload bytes, little-endian within each word
  function automatic logic [31:0] crc32_bytes(input logic [31:0] w[$]);
    logic [31:0] c;
    logic [7:0]  b;
    c = 32'hFFFF_FFFF;
    foreach (w[i]) begin
      for (int k = 0; k < 4; k++) begin
        b = w[i][8*k +: 8];
        c = c ^ {24'd0, b};
        for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      end
    end
    return ~c;
  endfunction

  // Frame-level reference model: where in the frame we are, words left, payload seen
  int            m_phase;      // 0 hunting, 1 header, 2 payload, 3 trailer
  int            m_left;
  int            m_silent;
  logic [31:0]   m_pay[$];
  logic [31:0]   e_data;
  logic          e_valid, e_busy, e_done, e_err;
  logic [1:0]    e_code;

  task automatic model_reset();
    m_phase = 0; m_left = 0; m_silent = 0; m_pay.delete();
    e_data = '0; e_valid = 0; e_busy = 0; e_done = 0; e_err = 0; e_code = 2'b00;
  endtask

  task automatic end_frame(input logic err, input logic [1:0] code);
    m_phase = 0; m_silent = 0; e_busy = 0;
    if (err) begin e_err = 1; e_code = code; end
  endtask

  task automatic model_step();
    e_valid = 0; e_done = 0;
    if (m_phase == 0) begin
      if (valid_i && data_i == SYNC) begin
        m_phase = 1; m_silent = 0; m_pay.delete();
        e_busy = 1; e_err = 0; e_code = 2'b00;
      end
    end else if (abort_i) begin
      end_frame(1'b0, 2'b00);
    end else if (valid_i) begin
      m_silent = 0;
      if (m_phase == 1) begin
        if (data_i == 0 || data_i > MAXL) end_frame(1'b1, 2'b01);
        else begin m_left = int'(data_i); m_phase = 2; end
      end else if (m_phase == 2) begin
        e_data = data_i; e_valid = 1; m_pay.push_back(data_i);
        m_left--;
        if (m_left == 0) m_phase = 3;
      end else begin
`ifdef BITSTREAM_CRC_EN
        if (data_i == crc32_bytes(m_pay)) begin end_frame(1'b0, 2'b00); e_done = 1; end
        else end_frame(1'b1, 2'b10);
`else
        end_frame(1'b0, 2'b00); e_done = 1;
`endif
      end
    end else begin
      m_silent++;
      if (m_silent == TMO) end_frame(1'b1, 2'b11);
    end
  endtask

  // Compare process: just after each rising edge, advance the model and check all outputs
  initial begin
    model_reset();
    forever begin
      @(posedge clk); #1;
      if (!rst_n) model_reset(); else model_step();
      chk("data_o", data_o, e_data);
      chk("valid_o", {31'd0, valid_o}, {31'd0, e_valid});
      chk("busy_o", {31'd0, busy_o}, {31'd0, e_busy});
      chk("done_o", {31'd0, done_o}, {31'd0, e_done});
      chk("error_o", {31'd0, error_o}, {31'd0, e_err});
      chk("err_code_o", {30'd0, err_code_o}, {30'd0, e_code});
      if (valid_o === 1'b1) mon_valid++;
      if (done_o === 1'b1) mon_done++;
    end
  end

  // ---------------------------------------------------------------- stimulus
  task automatic word(input logic [31:0] d, input bit ab, input int gap);
    data_i = d; valid_i = 1'b1; abort_i = ab;
    @(negedge clk);
    valid_i = 1'b0; abort_i = 1'b0; data_i = $urandom;
    repeat (gap) @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frame(input logic [31:0] q[$], input logic [31:0] trailer);
    word(SYNC, 0, $urandom_range(0, 2));
    word(32'(q.size()), 0, $urandom_range(0, 2));
    foreach (q[i]) word(q[i], 0, $urandom_range(0, 2));
    word(trailer, 0, 0);
  endtask

  initial begin
    logic [31:0] q[$];
    int v0, d0, n, kind;

    repeat (3) @(negedge clk);
    chk("reset busy_o", {31'd0, busy_o}, 32'd0);
    chk("reset err_code_o", {30'd0, err_code_o}, 32'd0);
    rst_n = 1'b1;
    idle(2);

    // Single zero word with its known CRC-32
    v0 = mon_valid; d0 = mon_done;
    q = '{32'h0000_0000};
    frame(q, 32'h2144_DF1C);
    idle(2);
    chk("t1 valid count", 32'(mon_valid - v0), 32'd1);
    chk("t1 done count", 32'(mon_done - d0), 32'd1);
    chk("t1 data_o", data_o, 32'h0000_0000);
    chk("t1 error_o", {31'd0, error_o}, 32'd0);
    chk("t1 busy_o", {31'd0, busy_o}, 32'd0);

    // Junk ahead of sync is dropped
    v0 = mon_valid; d0 = mon_done;
    word(32'h1234_5678, 0, 0);
    word(32'hDEAD_BEEF, 0, 1);
    chk("t2 busy before sync", {31'd0, busy_o}, 32'd0);
    chk("t2 no valid before sync", 32'(mon_valid - v0), 32'd0);
    q = '{32'hCAFE_0001, SYNC, 32'h0BAD_F00D};
    frame(q, crc32_bytes(q));
    idle(2);
    chk("t2 valid count", 32'(mon_valid - v0), 32'd3);
    chk("t2 done count", 32'(mon_done - d0), 32'd1);

    // Length header boundaries
    word(SYNC, 0, 0); word(32'd0, 0, 1);
    chk("t3 len0 error_o", {31'd0, error_o}, 32'd1);
    chk("t3 len0 code", {30'd0, err_code_o}, 32'd1);
    word(SYNC, 0, 0); word(32'(MAXL + 1), 0, 1);
    chk("t3 lenmax+1 code", {30'd0, err_code_o}, 32'd1);
    chk("t3 lenmax+1 busy", {31'd0, busy_o}, 32'd0);
    v0 = mon_valid;
    q.delete(); for (int i = 0; i < MAXL; i++) q.push_back($urandom);
    frame(q, crc32_bytes(q));
    idle(2);
    chk("t3 lenmax valid count", 32'(mon_valid - v0), 32'(MAXL));
    chk("t3 lenmax error_o", {31'd0, error_o}, 32'd0);

    // Corrupted trailer
    v0 = mon_valid; d0 = mon_done;
    q = '{32'h0000_0000};
    frame(q, 32'h2144_DF1D);
    idle(2);
    chk("t4 valid count", 32'(mon_valid - v0), 32'd1);
`ifdef BITSTREAM_CRC_EN
    chk("t4 done count", 32'(mon_done - d0), 32'd0);
    chk("t4 code", {30'd0, err_code_o}, 32'd2);
`else
    chk("t4 done count", 32'(mon_done - d0), 32'd1);
    chk("t4 error_o", {31'd0, error_o}, 32'd0);
`endif

    // Timeout inside payload, then a fresh sync clears the error
    word(SYNC, 0, 0); word(32'd4, 0, 0); word(32'h1, 0, 0); word(32'h2, 0, 0);
    idle(TMO + 3);
    chk("t5 code", {30'd0, err_code_o}, 32'd3);
    chk("t5 busy", {31'd0, busy_o}, 32'd0);
    word(SYNC, 0, 1);
    chk("t5 error cleared", {31'd0, error_o}, 32'd0);
    word(32'd0, 0, 1);

    // Abort coincident with the third payload word
    v0 = mon_valid; d0 = mon_done;
    word(SYNC, 0, 0); word(32'd4, 0, 0); word(32'hA, 0, 0); word(32'hB, 0, 0);
    word(32'hC, 1, 0);
    chk("t6 busy after abort", {31'd0, busy_o}, 32'd0);
    idle(2);
    chk("t6 valid count", 32'(mon_valid - v0), 32'd2);
    chk("t6 done count", 32'(mon_done - d0), 32'd0);
    chk("t6 error_o", {31'd0, error_o}, 32'd0);
    q = '{32'h5};
    frame(q, crc32_bytes(q));
    idle(2);
    chk("t6 fresh frame done", 32'(mon_done - d0), 32'd1);

    // Randomized frames of mixed kinds; the per-cycle model checks everything
    for (int f = 0; f < 40; f++) begin
      kind = $urandom_range(0, 9);
      n = $urandom_range(1, MAXL);
      q.delete();
      for (int i = 0; i < n; i++) q.push_back(($urandom_range(0, 7) == 0) ? SYNC : 32'($urandom));
      if (kind == 3) begin word($urandom, 0, 0); word(SYNC + 1, 0, 1); end
      if (kind == 0) begin
        word(SYNC, 0, 0);
        word(($urandom_range(0, 1) == 1) ? 32'd0 : 32'(MAXL + $urandom_range(1, 100)), 0, 1);
      end else if (kind == 1) begin
        word(SYNC, 0, 0); word(32'(n), 0, 0);
        for (int i = 0; i < $urandom_range(0, n - 1); i++) word(q[i], 0, $urandom_range(0, 2));
        word($urandom, 1, 1);
      end else if (kind == 2) begin
        frame(q, crc32_bytes(q) ^ (32'd1 << $urandom_range(0, 31)));
      end else begin
        frame(q, crc32_bytes(q));
      end
      idle($urandom_range(1, 3));
    end
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
